// File: rtl/mod_mult_seq_23x23_if.sv
// Handshake and data bundle for the sequential 23x23 multiplier.
//   start   : request strobe from the requester, sampled only while the multiplier is idle
//   a, b    : operands, captured on the accepting edge
//   busy    : high while a multiplication is in progress
//   done    : one-cycle pulse, product valid while high
//   product : a*b zero-extended to P_W bits, held until the next completion
// master = requester side, slave = multiplier side.
interface mod_mult_seq_23x23_if #(
   parameter int unsigned A_W = 23,
   parameter int unsigned P_W = 48
);
   logic           start;
   logic [A_W-1:0] a;
   logic [A_W-1:0] b;
   logic           busy;
   logic           done;
   logic [P_W-1:0] product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );
endinterface

// File: rtl/mod_mult_seq_23x23.sv
// Radix-2 shift-and-add unsigned multiplier, one multiplier bit per clock.
// Produces the 48-bit product that feeds the fixed-modulus reduction stage.
//   clk_i  : clock, all state updates on the rising edge
//   rst_i  : synchronous active-high reset, aborts any operation in flight
//   mul_io : slave side of mod_mult_seq_23x23_if (start/a/b in, busy/done/product out)
// Latency is A_W cycles from accept to done; a new start is accepted in the done cycle.
module mod_mult_seq_23x23 #(
   parameter int unsigned A_W = 23,
   parameter int unsigned P_W = 48
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   mod_mult_seq_23x23_if.slave  mul_io
);

   localparam int unsigned AccW = 2 * A_W;
   localparam int unsigned CntW = $clog2(A_W) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(A_W - 1);

   if (P_W < AccW) begin : g_bad_pw
      $error("P_W must be at least 2*A_W");
   end

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e          state_q, state_d;
   logic [AccW-1:0] a_sh_q, a_sh_d;
   logic [A_W-1:0]  b_sh_q, b_sh_d;
   logic [AccW-1:0] acc_q, acc_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [P_W-1:0]  product_q, product_d;
   logic            done_q, done_d;
   logic [AccW-1:0] acc_sum;

   // Product never exceeds 2*A_W bits, so this add cannot overflow.
   assign acc_sum = acc_q + (b_sh_q[0] ? a_sh_q : '0);

   always_comb begin
      state_d   = state_q;
      a_sh_d    = a_sh_q;
      b_sh_d    = b_sh_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mul_io.start) begin
               a_sh_d              = '0;
               a_sh_d[A_W-1:0]     = mul_io.a;
               b_sh_d              = mul_io.b;
               acc_d               = '0;
               cnt_d               = '0;
               state_d             = StBusy;
            end
         end
         StBusy: begin
            acc_d  = acc_sum;
            a_sh_d = a_sh_q << 1;
            b_sh_d = b_sh_q >> 1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               // Capture includes this edge's addition; upper bits zero-filled.
               product_d           = '0;
               product_d[AccW-1:0] = acc_sum;
               done_d              = 1'b1;
               state_d             = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         a_sh_q    <= '0;
         b_sh_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sh_q    <= a_sh_d;
         b_sh_q    <= b_sh_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign mul_io.busy    = (state_q == StBusy);
   assign mul_io.done    = done_q;
   assign mul_io.product = product_q;

endmodule
